// File: rtl/sreg_chip_emu.sv
// Responder-side emulator of the pixel IC configuration/readout shift register.
// Samples the host's shift/sclk/serial/write_cfg/pclk levels in the clk domain and acts on their rising edges.
module sreg_chip_emu #(
    parameter int SREG_LEN    = 42,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift,
    input  logic                sclk,
    input  logic                serial_in,
    input  logic                write_cfg,
    input  logic                pclk,
    output logic [1:0]          sreg_out,
    input  logic [SREG_LEN-1:0] pix_data,
    output logic [SREG_LEN-1:0] cfg0,
    output logic [SREG_LEN-1:0] cfg1,
    output logic                cfg0_upd,
    output logic                cfg1_upd,
    output logic                pix_loaded,
    output logic [CNT_W-1:0]    shift_cnt,
    output logic                frame_ovf
);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Bit order {shift, sclk, serial_in, write_cfg, pclk}; sclk idles high so no false edge out of reset.
    localparam logic [4:0]       IN_RST  = 5'b01000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(SREG_LEN);

    logic [4:0]          w_raw;
    logic [4:0]          w_cur;
    logic [4:0]          r_prev;
    logic                w_shift, w_sclk_rise, w_serial, w_wcfg, w_wcfg_rise, w_pclk, w_pclk_rise;

    state_t              r_state, w_state_nxt;
    logic [SREG_LEN-1:0] r_sr, w_sr_nxt;
    logic [SREG_LEN-1:0] r_cfg0, w_cfg0_nxt;
    logic [SREG_LEN-1:0] r_cfg1, w_cfg1_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_cfg0_upd, w_cfg0_upd_nxt;
    logic                r_cfg1_upd, w_cfg1_upd_nxt;
    logic                r_pix_loaded, w_pix_loaded_nxt;
    logic                r_frame_ovf, w_frame_ovf_nxt;

    assign w_raw = {shift, sclk, serial_in, write_cfg, pclk};

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [4:0] r_sync [SYNC_STAGES];
            // Input synchronizer chain for pin-driven operation.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= IN_RST;
                end else begin
                    r_sync[0] <= w_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_cur = r_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_cur = w_raw;
        end
    endgenerate

    // Previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) r_prev <= IN_RST;
        else        r_prev <= w_cur;
    end

    assign w_shift     = w_cur[4];
    assign w_sclk_rise = w_cur[3] & ~r_prev[3];
    assign w_serial    = w_cur[2];
    assign w_wcfg      = w_cur[1];
    assign w_wcfg_rise = w_cur[1] & ~r_prev[1];
    assign w_pclk      = w_cur[0];
    assign w_pclk_rise = w_cur[0] & ~r_prev[0];

    // Next-state and datapath decode; latches always capture the pre-shift register contents.
    always_comb begin
        w_state_nxt      = r_state;
        w_sr_nxt         = r_sr;
        w_cfg0_nxt       = r_cfg0;
        w_cfg1_nxt       = r_cfg1;
        w_cnt_nxt        = r_cnt;
        w_cfg0_upd_nxt   = 1'b0;
        w_cfg1_upd_nxt   = 1'b0;
        w_pix_loaded_nxt = 1'b0;
        w_frame_ovf_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_shift) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (!w_shift) begin
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_sr_nxt        = {r_sr[SREG_LEN-2:0], w_serial};
                    w_frame_ovf_nxt = (r_cnt == CNT_LEN);
                    if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    else                  w_cnt_nxt = r_cnt;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_pclk_rise && !w_shift && !w_wcfg) begin
            w_sr_nxt         = pix_data;
            w_pix_loaded_nxt = 1'b1;
        end else begin
            w_pix_loaded_nxt = 1'b0;
        end

        if (w_wcfg_rise) begin
            if (w_pclk) begin
                w_cfg1_nxt     = r_sr;
                w_cfg1_upd_nxt = 1'b1;
            end else begin
                w_cfg0_nxt     = r_sr;
                w_cfg0_upd_nxt = 1'b1;
            end
        end else begin
            w_cfg0_upd_nxt = 1'b0;
            w_cfg1_upd_nxt = 1'b0;
        end
    end

    // State, shift register, config banks and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sr         <= {SREG_LEN{1'b0}};
            r_cfg0       <= {SREG_LEN{1'b0}};
            r_cfg1       <= {SREG_LEN{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_cfg0_upd   <= 1'b0;
            r_cfg1_upd   <= 1'b0;
            r_pix_loaded <= 1'b0;
            r_frame_ovf  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_cfg0       <= w_cfg0_nxt;
            r_cfg1       <= w_cfg1_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cfg0_upd   <= w_cfg0_upd_nxt;
            r_cfg1_upd   <= w_cfg1_upd_nxt;
            r_pix_loaded <= w_pix_loaded_nxt;
            r_frame_ovf  <= w_frame_ovf_nxt;
        end
    end

    assign sreg_out   = {r_sr[SREG_LEN/2-1], r_sr[SREG_LEN-1]};
    assign cfg0       = r_cfg0;
    assign cfg1       = r_cfg1;
    assign cfg0_upd   = r_cfg0_upd;
    assign cfg1_upd   = r_cfg1_upd;
    assign pix_loaded = r_pix_loaded;
    assign shift_cnt  = r_cnt;
    assign frame_ovf  = r_frame_ovf;

endmodule

// File: tb/tb_sreg_chip_emu.sv
// Scoreboard bench for sreg_chip_emu: a reference model of the chain predicts readout and bank contents.
// A second instance built with two input sync stages shares the stimulus to check the added latency.
module tb_sreg_chip_emu;

    logic        clk = 1'b0;
    logic        rst_n, shift, sclk, serial_in, write_cfg, pclk;
    logic [41:0] pix_data;
    logic [1:0]  sreg_out, sreg_out2;
    logic [41:0] cfg0, cfg1, cfg0_2, cfg1_2;
    logic        cfg0_upd, cfg1_upd, pix_loaded, frame_ovf;
    logic        cfg0_upd2, cfg1_upd2, pix_loaded2, frame_ovf2;
    logic [6:0]  shift_cnt, shift_cnt2;

    int checks = 0;
    int errors = 0;

    logic [41:0] m_sr, m_cfg0, m_cfg1;
    logic [6:0]  m_cnt;
    logic [1:0]  q_out[$];
    logic [41:0] q_cfg[$];

    localparam logic [41:0] WORD_A = 42'h2AB_CDEF_0123;
    localparam logic [41:0] WORD_B = 42'h155_5555_5555;
    localparam logic [41:0] WORD_P = 42'h3FF_0000_0F0F;

    sreg_chip_emu #(.SREG_LEN(42), .SYNC_STAGES(0), .CNT_W(7)) u_dut (
        .clk(clk), .rst_n(rst_n), .shift(shift), .sclk(sclk), .serial_in(serial_in),
        .write_cfg(write_cfg), .pclk(pclk), .sreg_out(sreg_out), .pix_data(pix_data),
        .cfg0(cfg0), .cfg1(cfg1), .cfg0_upd(cfg0_upd), .cfg1_upd(cfg1_upd),
        .pix_loaded(pix_loaded), .shift_cnt(shift_cnt), .frame_ovf(frame_ovf));

    sreg_chip_emu #(.SREG_LEN(42), .SYNC_STAGES(2), .CNT_W(7)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .shift(shift), .sclk(sclk), .serial_in(serial_in),
        .write_cfg(write_cfg), .pclk(pclk), .sreg_out(sreg_out2), .pix_data(pix_data),
        .cfg0(cfg0_2), .cfg1(cfg1_2), .cfg0_upd(cfg0_upd2), .cfg1_upd(cfg1_upd2),
        .pix_loaded(pix_loaded2), .shift_cnt(shift_cnt2), .frame_ovf(frame_ovf2));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; shift = 1'b0; sclk = 1'b1; serial_in = 1'b0;
        write_cfg = 1'b0; pclk = 1'b0; pix_data = 42'd0;
        m_sr = 42'd0; m_cfg0 = 42'd0; m_cfg1 = 42'd0; m_cnt = 7'd0;
        q_out.delete(); q_cfg.delete();
        repeat (4) step();
        rst_n = 1'b1;
        step();
    endtask

    // One sclk rise; the model shifts only when the chip is expected to be in SHIFT.
    task automatic sclk_rise(input logic d, input bit active);
        logic [1:0] e_out;
        logic       e_ovf;
        serial_in = d; sclk = 1'b0;
        step();
        checks++;
        if (frame_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_idle: got %b want 0", frame_ovf);
        end
        sclk = 1'b1;
        e_ovf = 1'b0;
        if (active) begin
            e_ovf = (m_cnt == 7'd42);
            m_sr  = {m_sr[40:0], d};
            if (m_cnt != 7'd127) m_cnt = m_cnt + 7'd1;
        end
        q_out.push_back({m_sr[20], m_sr[41]});
        step();
        e_out = q_out.pop_front();
        checks++;
        if (sreg_out !== e_out) begin
            errors++; $display("FAIL sreg_out: got %b want %b", sreg_out, e_out);
        end
        checks++;
        if (frame_ovf !== e_ovf) begin
            errors++; $display("FAIL frame_ovf: got %b want %b (cnt %0d)", frame_ovf, e_ovf, m_cnt);
        end
        checks++;
        if (shift_cnt !== m_cnt) begin
            errors++; $display("FAIL shift_cnt: got %0d want %0d", shift_cnt, m_cnt);
        end
    endtask

    // Latch the chain into a bank; bank 1 raises pclk together with write_cfg.
    task automatic latch_cfg(input logic bank);
        logic [41:0] e_cfg;
        write_cfg = 1'b1; pclk = bank;
        q_cfg.push_back(m_sr);
        step();
        e_cfg = q_cfg.pop_front();
        if (bank) m_cfg1 = e_cfg; else m_cfg0 = e_cfg;
        checks++;
        if ({cfg1_upd, cfg0_upd} !== (bank ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL cfg_upd: got %b want %b", {cfg1_upd, cfg0_upd}, (bank ? 2'b10 : 2'b01));
        end
        checks++;
        if (cfg0 !== m_cfg0 || cfg1 !== m_cfg1) begin
            errors++; $display("FAIL cfg_value: got %h/%h want %h/%h", cfg0, cfg1, m_cfg0, m_cfg1);
        end
        checks++;
        if (pix_loaded !== 1'b0 || sreg_out !== {m_sr[20], m_sr[41]}) begin
            errors++; $display("FAIL latch_no_load: got pix_loaded=%b sreg_out=%b want 0/%b", pix_loaded, sreg_out, {m_sr[20], m_sr[41]});
        end
        step();
        checks++;
        if ({cfg1_upd, cfg0_upd} !== 2'b00) begin
            errors++; $display("FAIL cfg_upd_held: got %b want 00", {cfg1_upd, cfg0_upd});
        end
        write_cfg = 1'b0; pclk = 1'b0;
        step();
    endtask

    task automatic enter_shift();
        shift = 1'b1;
        step();
        step();
        m_cnt = 7'd0;
        checks++;
        if (shift_cnt !== m_cnt) begin
            errors++; $display("FAIL cnt_clear: got %0d want %0d", shift_cnt, m_cnt);
        end
    endtask

    task automatic leave_shift();
        shift = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sreg_out !== 2'b00 || cfg0 !== 42'd0 || cfg1 !== 42'd0 || shift_cnt !== 7'd0 ||
            {cfg0_upd, cfg1_upd, pix_loaded, frame_ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_state: got out=%b cfg0=%h cfg1=%h cnt=%0d pulses=%b want all zero",
                               sreg_out, cfg0, cfg1, shift_cnt, {cfg0_upd, cfg1_upd, pix_loaded, frame_ovf});
        end
    endtask

    task automatic test_shift_in();
        enter_shift();
        for (int k = 41; k >= 0; k--) sclk_rise(WORD_A[k], 1'b1);
        leave_shift();
        checks++;
        if (shift_cnt !== 7'd42) begin
            errors++; $display("FAIL shift_in_cnt: got %0d want 42", shift_cnt);
        end
    endtask

    task automatic test_cfg_latch();
        latch_cfg(1'b0);
        enter_shift();
        for (int k = 41; k >= 0; k--) sclk_rise(WORD_B[k], 1'b1);
        leave_shift();
        pix_data = ~m_sr;
        latch_cfg(1'b1);
        checks++;
        if (cfg0 !== WORD_A || cfg1 !== WORD_B) begin
            errors++; $display("FAIL banks: got %h/%h want %h/%h", cfg0, cfg1, WORD_A, WORD_B);
        end
    endtask

    task automatic test_pix_load();
        pix_data = WORD_P;
        pclk = 1'b1;
        m_sr = WORD_P;
        q_out.push_back({m_sr[20], m_sr[41]});
        step();
        checks++;
        if (pix_loaded !== 1'b1 || sreg_out !== q_out.pop_front()) begin
            errors++; $display("FAIL pix_load: got pix_loaded=%b sreg_out=%b want 1/%b", pix_loaded, sreg_out, {m_sr[20], m_sr[41]});
        end
        step();
        checks++;
        if (pix_loaded !== 1'b0) begin
            errors++; $display("FAIL pix_held: got %b want 0", pix_loaded);
        end
        pclk = 1'b0;
        step();
        enter_shift();
        for (int k = 0; k < 21; k++) sclk_rise(1'b0, 1'b1);
        leave_shift();
        latch_cfg(1'b0);
    endtask

    task automatic test_ovf();
        int ovf_seen = 0;
        enter_shift();
        for (int k = 0; k < 44; k++) begin
            sclk_rise(logic'($urandom_range(1, 0)), 1'b1);
            ovf_seen += int'(frame_ovf);
        end
        checks++;
        if (ovf_seen != 1 || shift_cnt !== 7'd44) begin
            errors++; $display("FAIL ovf_burst: got %0d pulses cnt=%0d want 1 pulse cnt=44", ovf_seen, shift_cnt);
        end
        leave_shift();
        checks++;
        if (shift_cnt !== 7'd44) begin
            errors++; $display("FAIL cnt_hold: got %0d want 44", shift_cnt);
        end
        enter_shift();
    endtask

    task automatic test_pclk_in_shift();
        pix_data = ~m_sr;
        pclk = 1'b1;
        step();
        checks++;
        if (pix_loaded !== 1'b0 || sreg_out !== {m_sr[20], m_sr[41]}) begin
            errors++; $display("FAIL pclk_in_shift: got pix_loaded=%b sreg_out=%b want 0/%b", pix_loaded, sreg_out, {m_sr[20], m_sr[41]});
        end
        pclk = 1'b0;
        sclk_rise(1'b1, 1'b1);
        sclk_rise(~m_sr[41], 1'b1);
        leave_shift();
        for (int k = 0; k < 3; k++) sclk_rise(~m_sr[40], 1'b0);
    endtask

    task automatic test_reset_mid();
        enter_shift();
        for (int k = 0; k < 20; k++) sclk_rise(1'b1, 1'b1);
        rst_n = 1'b0;
        step();
        checks++;
        if (sreg_out !== 2'b00 || cfg0 !== 42'd0 || cfg1 !== 42'd0 || shift_cnt !== 7'd0) begin
            errors++; $display("FAIL reset_mid: got out=%b cfg0=%h cfg1=%h cnt=%0d want zeros", sreg_out, cfg0, cfg1, shift_cnt);
        end
        do_reset();
    endtask

    task automatic test_sync_latency();
        enter_shift();
        for (int k = 41; k >= 0; k--) sclk_rise(WORD_A[k], 1'b1);
        checks++;
        if (shift_cnt2 !== m_cnt - 7'd1) begin
            errors++; $display("FAIL sync_lat1: got %0d want %0d", shift_cnt2, m_cnt - 7'd1);
        end
        step();
        checks++;
        if (shift_cnt2 !== m_cnt - 7'd1) begin
            errors++; $display("FAIL sync_lat2: got %0d want %0d", shift_cnt2, m_cnt - 7'd1);
        end
        step();
        checks++;
        if (shift_cnt2 !== m_cnt || sreg_out2 !== {WORD_A[20], WORD_A[41]}) begin
            errors++; $display("FAIL sync_lat3: got cnt=%0d out=%b want %0d/%b", shift_cnt2, sreg_out2, m_cnt, {WORD_A[20], WORD_A[41]});
        end
        leave_shift();
    endtask

    initial begin
        test_reset();
        test_shift_in();
        test_cfg_latch();
        test_pix_load();
        test_ovf();
        test_pclk_in_shift();
        test_reset_mid();
        test_sync_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
